// File: rtl/payment_fsm_multi.sv
// ---------------------------------------------------------------------------
// payment_fsm_multi
//
// Sequences one card transaction: network selection, amount confirmation,
// PIN entry (with a retry limit), then payment processing. Outputs are Moore
// outputs decoded from the state register. The only exceptions are the
// registered choice_error pulse and the held status registers.
//
// Optional feature macro: WAIT_TIMEOUT_EN
//   defined   -> each WAIT_* state times out after TIMEOUT_CYCLES cycles
//                (abort_code 5).
//   undefined -> WAIT_* states wait indefinitely.
//
// Ports
//   clk                  in   system clock, rising edge
//   reset                in   synchronous, active-high reset
//   process_init         in   start transaction (sampled in IDLE)
//   choice_in            in   one-hot card-network selection [NUM_CARDS]
//   user_cancel          in   abort request
//   pymt_amt_conf        in   amount accepted
//   pymt_amt_denied      in   amount rejected
//   pin_success          in   PIN engine: correct PIN
//   pin_fail             in   PIN engine: wrong PIN
//   transaction_success  in   payment engine: approved
//   transaction_fail     in   payment engine: declined
//   light_bit            out  high in WAIT_CARD
//   card_choice          out  selected index+1, 0 = none
//   choice_error         out  one-cycle pulse after an invalid choice_in
//   pymt_amt_print       out  high in WAIT_AMT
//   pin_process_init     out  high in WAIT_PIN
//   pymt_process_init    out  high in WAIT_PYMT
//   process_done         out  high in SUCCESS
//   process_abort        out  high in FAIL
//   abort_code           out  reason for the last abort (0 none .. 5 timeout)
//   fail_count           out  PIN failures in this transaction
// ---------------------------------------------------------------------------
module payment_fsm_multi #(
    parameter int NUM_CARDS      = 3,
    parameter int MAX_PIN_TRIES  = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             process_init,
    input  logic [NUM_CARDS-1:0]             choice_in,
    input  logic                             user_cancel,
    input  logic                             pymt_amt_conf,
    input  logic                             pymt_amt_denied,
    input  logic                             pin_success,
    input  logic                             pin_fail,
    input  logic                             transaction_success,
    input  logic                             transaction_fail,
    output logic                             light_bit,
    output logic [$clog2(NUM_CARDS+1)-1:0]   card_choice,
    output logic                             choice_error,
    output logic                             pymt_amt_print,
    output logic                             pin_process_init,
    output logic                             pymt_process_init,
    output logic                             process_done,
    output logic                             process_abort,
    output logic [2:0]                       abort_code,
    output logic [3:0]                       fail_count
);

    localparam int         CW        = $clog2(NUM_CARDS + 1);
    localparam logic [3:0] MAX_TRIES = 4'(MAX_PIN_TRIES);

    if (NUM_CARDS < 2 || MAX_PIN_TRIES < 1 || MAX_PIN_TRIES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("payment_fsm_multi: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CARD = 3'd1,
        CARD_SEL  = 3'd2,
        WAIT_AMT  = 3'd3,
        WAIT_PIN  = 3'd4,
        WAIT_PYMT = 3'd5,
        SUCCESS   = 3'd6,
        FAIL      = 3'd7
    } state_e;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_DENIED  = 3'd1;
    localparam logic [2:0] CODE_PIN     = 3'd2;
    localparam logic [2:0] CODE_DECLINE = 3'd3;
    localparam logic [2:0] CODE_CANCEL  = 3'd4;

    state_e          state_q, state_d;
    logic [CW-1:0]   card_choice_q, card_choice_d;
    logic            choice_err_q, choice_err_d;
    logic [3:0]      fail_count_q, fail_count_d;
    logic [2:0]      abort_code_q, abort_code_d;

    // Count set bits of choice_in and remember the (1-based) index of the
    // highest one; the index is only used when exactly one bit is set.
    logic [CW-1:0]   choice_ones;
    logic [CW-1:0]   choice_idx;

    always_comb begin
        choice_ones = '0;
        choice_idx  = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (choice_in[i]) begin
                choice_ones = choice_ones + 1'b1;
                choice_idx  = CW'(i + 1);
            end
        end
    end

    logic in_active;
    assign in_active = (state_q inside {WAIT_CARD, CARD_SEL, WAIT_AMT, WAIT_PIN, WAIT_PYMT});

`ifdef WAIT_TIMEOUT_EN
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] CODE_TIME = 3'd5;
    logic [TW-1:0] timer_q, timer_d;
    logic          in_wait;
    logic          qualifying;
    assign in_wait = (state_q inside {WAIT_CARD, WAIT_AMT, WAIT_PIN, WAIT_PYMT});
`endif

    // State register and held status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            card_choice_q <= '0;
            choice_err_q  <= 1'b0;
            fail_count_q  <= '0;
            abort_code_q  <= CODE_NONE;
`ifdef WAIT_TIMEOUT_EN
            timer_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            card_choice_q <= card_choice_d;
            choice_err_q  <= choice_err_d;
            fail_count_q  <= fail_count_d;
            abort_code_q  <= abort_code_d;
`ifdef WAIT_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d       = state_q;
        card_choice_d = card_choice_q;
        choice_err_d  = 1'b0;
        fail_count_d  = fail_count_q;
        abort_code_d  = abort_code_q;

        case (state_q)
            IDLE: begin
                if (process_init) begin
                    state_d      = WAIT_CARD;
                    abort_code_d = CODE_NONE;
                    fail_count_d = '0;
                end
            end
            WAIT_CARD: begin
                if (choice_ones == CW'(1)) begin
                    state_d       = CARD_SEL;
                    card_choice_d = choice_idx;
                end else if (choice_ones > CW'(1)) begin
                    choice_err_d = 1'b1;
                end
            end
            CARD_SEL: state_d = WAIT_AMT;
            WAIT_AMT: begin
                if (pymt_amt_denied) begin
                    state_d      = FAIL;
                    abort_code_d = CODE_DENIED;
                end else if (pymt_amt_conf) begin
                    state_d = WAIT_PIN;
                end
            end
            WAIT_PIN: begin
                // A simultaneous success/fail is treated as a failure.
                if (pin_fail) begin
                    if (fail_count_q < MAX_TRIES) begin
                        fail_count_d = fail_count_q + 4'd1;
                    end
                    if (fail_count_q + 4'd1 >= MAX_TRIES) begin
                        state_d      = FAIL;
                        abort_code_d = CODE_PIN;
                    end
                end else if (pin_success) begin
                    state_d = WAIT_PYMT;
                end
            end
            WAIT_PYMT: begin
                if (transaction_fail) begin
                    state_d      = FAIL;
                    abort_code_d = CODE_DECLINE;
                end else if (transaction_success) begin
                    state_d = SUCCESS;
                end
            end
            SUCCESS, FAIL: begin
                state_d       = IDLE;
                card_choice_d = '0;
            end
            default: state_d = IDLE;
        endcase

`ifdef WAIT_TIMEOUT_EN
        // A pin_fail that stays in WAIT_PIN counts as activity, so it beats
        // the timeout and restarts the counter like a state change does.
        qualifying = (state_d != state_q) || (state_q == WAIT_PIN && pin_fail);
        if (in_wait && !qualifying && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d      = FAIL;
            abort_code_d = CODE_TIME;
            choice_err_d = 1'b0;
        end
`endif

        // Cancel outranks everything, including a pending PIN failure.
        if (in_active && user_cancel) begin
            state_d       = FAIL;
            abort_code_d  = CODE_CANCEL;
            card_choice_d = card_choice_q;
            fail_count_d  = fail_count_q;
            choice_err_d  = 1'b0;
        end

`ifdef WAIT_TIMEOUT_EN
        if (state_d != state_q || (state_q == WAIT_PIN && pin_fail) || !in_wait) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
`endif
    end

    // Moore output decode.
    always_comb begin
        light_bit         = (state_q == WAIT_CARD);
        pymt_amt_print    = (state_q == WAIT_AMT);
        pin_process_init  = (state_q == WAIT_PIN);
        pymt_process_init = (state_q == WAIT_PYMT);
        process_done      = (state_q == SUCCESS);
        process_abort     = (state_q == FAIL);
        card_choice       = card_choice_q;
        choice_error      = choice_err_q;
        abort_code        = abort_code_q;
        fail_count        = fail_count_q;
    end

endmodule

// File: tb/tb_payment_fsm_multi.sv
// ---------------------------------------------------------------------------
// tb_payment_fsm_multi
//
// Scoreboard bench for payment_fsm_multi. Stimulus is applied on the falling
// edge; a behavioural model predicts the outputs after the next rising edge
// and queues them. A monitor compares the queued prediction against the DUT
// shortly after every rising edge. Whenever the DUT shows process_done or
// process_abort, the monitor also checks the queued end-of-transaction record.
// ---------------------------------------------------------------------------
module tb_payment_fsm_multi;

    localparam int NC  = 3;
    localparam int MPT = 3;
    localparam int TO  = 16;
    localparam int CW  = $clog2(NC + 1);
`ifdef WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Stimulus word: {reset, init, cancel, conf, denied, psucc, pfail, tsucc, tfail, choice[2:0]}
    localparam logic [11:0] S_RST  = 12'h800;
    localparam logic [11:0] S_INIT = 12'h400;
    localparam logic [11:0] S_CAN  = 12'h200;
    localparam logic [11:0] S_CONF = 12'h100;
    localparam logic [11:0] S_DEN  = 12'h080;
    localparam logic [11:0] S_PS   = 12'h040;
    localparam logic [11:0] S_PF   = 12'h020;
    localparam logic [11:0] S_TS   = 12'h010;
    localparam logic [11:0] S_TF   = 12'h008;
    localparam logic [11:0] S_NOP  = 12'h000;

    typedef struct packed {
        logic          rst;
        logic          init;
        logic          cancel;
        logic          conf;
        logic          denied;
        logic          psucc;
        logic          pfail;
        logic          tsucc;
        logic          tfail;
        logic [NC-1:0] choice;
    } stim_t;

    // Model phases of a transaction.
    localparam int P_IDLE  = 0;
    localparam int P_CARD  = 1;
    localparam int P_SEL   = 2;
    localparam int P_AMT   = 3;
    localparam int P_PIN   = 4;
    localparam int P_PYMT  = 5;
    localparam int P_DONE  = 6;
    localparam int P_ABORT = 7;

    logic          clk;
    logic          reset;
    logic          process_init;
    logic [NC-1:0] choice_in;
    logic          user_cancel;
    logic          pymt_amt_conf;
    logic          pymt_amt_denied;
    logic          pin_success;
    logic          pin_fail;
    logic          transaction_success;
    logic          transaction_fail;
    logic          light_bit;
    logic [CW-1:0] card_choice;
    logic          choice_error;
    logic          pymt_amt_print;
    logic          pin_process_init;
    logic          pymt_process_init;
    logic          process_done;
    logic          process_abort;
    logic [2:0]    abort_code;
    logic [3:0]    fail_count;

    payment_fsm_multi #(
        .NUM_CARDS      (NC),
        .MAX_PIN_TRIES  (MPT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .process_init        (process_init),
        .choice_in           (choice_in),
        .user_cancel         (user_cancel),
        .pymt_amt_conf       (pymt_amt_conf),
        .pymt_amt_denied     (pymt_amt_denied),
        .pin_success         (pin_success),
        .pin_fail            (pin_fail),
        .transaction_success (transaction_success),
        .transaction_fail    (transaction_fail),
        .light_bit           (light_bit),
        .card_choice         (card_choice),
        .choice_error        (choice_error),
        .pymt_amt_print      (pymt_amt_print),
        .pin_process_init    (pin_process_init),
        .pymt_process_init   (pymt_process_init),
        .process_done        (process_done),
        .process_abort       (process_abort),
        .abort_code          (abort_code),
        .fail_count          (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];   // predicted output vector per cycle
    logic [8:0]  txn_q[$];   // predicted {abort_code, card_choice, fail_count} at done/abort

    // Model state.
    int m_ph    = P_IDLE;
    int m_card  = 0;
    int m_fails = 0;
    int m_code  = 0;
    int m_stay  = 0;
    bit m_err   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_wait(input int p);
        return (p == P_CARD) || (p == P_AMT) || (p == P_PIN) || (p == P_PYMT);
    endfunction

    function automatic logic [15:0] model_vec();
        return {m_ph == P_CARD, 2'(m_card), m_err, m_ph == P_AMT, m_ph == P_PIN,
                m_ph == P_PYMT, m_ph == P_DONE, m_ph == P_ABORT, 3'(m_code), 4'(m_fails)};
    endfunction

    // One clock of transaction rules.
    task automatic model_step(input stim_t s);
        int nxt;
        bit retry;
        nxt   = m_ph;
        retry = 1'b0;
        m_err = 1'b0;
        if (s.rst) begin
            m_ph = P_IDLE; m_card = 0; m_fails = 0; m_code = 0; m_stay = 0;
            return;
        end
        if (m_ph >= P_CARD && m_ph <= P_PYMT && s.cancel) begin
            nxt = P_ABORT; m_code = 4;
        end else begin
            case (m_ph)
                P_IDLE: if (s.init) begin nxt = P_CARD; m_code = 0; m_fails = 0; end
                P_CARD: begin
                    if ($countones(s.choice) == 1) begin
                        nxt = P_SEL; m_card = $clog2(s.choice) + 1;
                    end else if ($countones(s.choice) > 1) begin
                        m_err = 1'b1;
                    end
                end
                P_SEL:  nxt = P_AMT;
                P_AMT: begin
                    if (s.denied) begin nxt = P_ABORT; m_code = 1; end
                    else if (s.conf) nxt = P_PIN;
                end
                P_PIN: begin
                    if (s.pfail) begin
                        m_fails++;
                        if (m_fails >= MPT) begin nxt = P_ABORT; m_code = 2; end
                        else retry = 1'b1;
                    end else if (s.psucc) nxt = P_PYMT;
                end
                P_PYMT: begin
                    if (s.tfail) begin nxt = P_ABORT; m_code = 3; end
                    else if (s.tsucc) nxt = P_DONE;
                end
                default: begin nxt = P_IDLE; m_card = 0; end
            endcase
            if (TO_EN && is_wait(m_ph) && nxt == m_ph) begin
                if (retry) m_stay = 1;
                else if (m_stay >= TO) begin nxt = P_ABORT; m_code = 5; m_err = 1'b0; end
                else m_stay++;
            end
        end
        if (nxt != m_ph) m_stay = 1;
        if (nxt == P_DONE || nxt == P_ABORT) txn_q.push_back({3'(m_code), 2'(m_card), 4'(m_fails)});
        m_ph = nxt;
    endtask

    task automatic step(input logic [11:0] v);
        stim_t s;
        s = stim_t'(v);
        @(negedge clk);
        reset               = s.rst;
        process_init        = s.init;
        user_cancel         = s.cancel;
        pymt_amt_conf       = s.conf;
        pymt_amt_denied     = s.denied;
        pin_success         = s.psucc;
        pin_fail            = s.pfail;
        transaction_success = s.tsucc;
        transaction_fail    = s.tfail;
        choice_in           = s.choice;
        model_step(s);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(S_NOP);
    endtask

    function automatic logic [11:0] rand_stim();
        logic [11:0] v;
        logic [2:0]  one;
        v = '0;
        if ($urandom_range(0, 99) < 2)  v |= S_RST;
        if ($urandom_range(0, 99) < 30) v |= S_INIT;
        if ($urandom_range(0, 99) < 4)  v |= S_CAN;
        if ($urandom_range(0, 99) < 25) v |= S_CONF;
        if ($urandom_range(0, 99) < 10) v |= S_DEN;
        if ($urandom_range(0, 99) < 25) v |= S_PS;
        if ($urandom_range(0, 99) < 25) v |= S_PF;
        if ($urandom_range(0, 99) < 25) v |= S_TS;
        if ($urandom_range(0, 99) < 15) v |= S_TF;
        one = 3'b001 << $urandom_range(0, 2);
        case ($urandom_range(0, 3))
            0:       v[2:0] = 3'b000;
            1, 2:    v[2:0] = one;
            default: v[2:0] = 3'($urandom_range(0, 7));
        endcase
        return v;
    endfunction

    // Monitor: per-cycle output compare plus end-of-transaction records.
    initial begin
        logic [15:0] e;
        logic [8:0]  t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {light_bit, card_choice, choice_error, pymt_amt_print,
                                  pin_process_init, pymt_process_init, process_done,
                                  process_abort, abort_code, fail_count}, e);
            end
            if (process_done === 1'b1 || process_abort === 1'b1) begin
                if (txn_q.size() == 0) begin
                    check("txn_unexpected", 16'd1, 16'd0);
                end else begin
                    t = txn_q.pop_front();
                    check("txn_result", {7'd0, abort_code, card_choice, fail_count}, {7'd0, t});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; process_init = 1'b0; choice_in = '0; user_cancel = 1'b0;
        pymt_amt_conf = 1'b0; pymt_amt_denied = 1'b0; pin_success = 1'b0;
        pin_fail = 1'b0; transaction_success = 1'b0; transaction_fail = 1'b0;

        // Successful transaction with two PIN retries.
        step(S_RST);
        step(S_INIT); step(12'b010); step(S_NOP); step(S_CONF);
        step(S_PF); step(S_PF); step(S_PS); step(S_TS); idle(2);
        // Invalid choice, then valid choice, then amount denied.
        step(S_INIT); step(12'b110); step(12'b000); step(12'b001); step(S_NOP);
        step(S_DEN); idle(2);
        // PIN limit reached.
        step(S_INIT); step(12'b100); step(S_NOP); step(S_CONF);
        step(S_PF); step(S_PF); step(S_PF); idle(2);
        // Simultaneous PIN success/fail, then simultaneous payment results.
        step(S_INIT); step(12'b001); step(S_NOP); step(S_CONF);
        step(S_PS | S_PF); step(S_PS); step(S_TS | S_TF); idle(2);
        // Cancel beats a pending PIN failure.
        step(S_INIT); step(12'b010); step(S_NOP); step(S_CONF); step(S_CAN | S_PF); idle(2);
        // Cancel in WAIT_PYMT, then reset in WAIT_AMT.
        step(S_INIT); step(12'b010); step(S_NOP); step(S_CONF); step(S_PS);
        step(S_CAN | S_TS); idle(2);
        step(S_INIT); step(12'b001); step(S_NOP); step(S_RST | S_DEN); idle(2);
        // Long stall in WAIT_AMT (times out only when the feature is built in).
        step(S_INIT); step(12'b001); step(S_NOP); idle(40); idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) step(rand_stim());
        idle(3);
        @(negedge clk);
        check("exp_queue_drained", 16'(exp_q.size()), 16'd0);
        check("txn_queue_drained", 16'(txn_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
